// File: rtl/axi_xbar_nport.sv
// axi_xbar_nport: one AXI4 master fanned out to NS address-windowed slaves.
// Read (AR/R) and write (AW/W/B) paths are independent, each allowing one
// outstanding burst. AR/AW/W payloads are broadcast to every slave; only the
// valid/ready pairs are steered, and R/B are muxed back from the latched slave.
// All channels pass through combinationally; the only state is the per-path
// FSM with its latched slave select, ID and decode-error beat counter.
// Build option AXI_XBAR_DECERR_EN: unmapped requests are accepted and answered
// by an internal DECERR responder. Without it an unmapped request is never
// accepted and no slave sees a valid.
module axi_xbar_nport #(
  parameter int NS  = 2,
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int IDW = 4,
  parameter logic [NS*AW-1:0] SLV_BASE = '0,
  parameter logic [NS*AW-1:0] SLV_MASK = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  // master read address
  input  logic [AW-1:0]         s_araddr,
  input  logic [IDW-1:0]        s_arid,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  // master read data
  output logic [DW-1:0]         s_rdata,
  output logic [IDW-1:0]        s_rid,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  // master write address
  input  logic [AW-1:0]         s_awaddr,
  input  logic [IDW-1:0]        s_awid,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  // master write data
  input  logic [DW-1:0]         s_wdata,
  input  logic [DW/8-1:0]       s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  // master write response
  output logic [IDW-1:0]        s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // slave read address, slave i at slice i
  output logic [NS*AW-1:0]      m_araddr,
  output logic [NS*IDW-1:0]     m_arid,
  output logic [NS*8-1:0]       m_arlen,
  output logic [NS*3-1:0]       m_arsize,
  output logic [NS*2-1:0]       m_arburst,
  output logic [NS-1:0]         m_arvalid,
  input  logic [NS-1:0]         m_arready,
  // slave read data
  input  logic [NS*DW-1:0]      m_rdata,
  input  logic [NS*IDW-1:0]     m_rid,
  input  logic [NS*2-1:0]       m_rresp,
  input  logic [NS-1:0]         m_rlast,
  input  logic [NS-1:0]         m_rvalid,
  output logic [NS-1:0]         m_rready,
  // slave write address
  output logic [NS*AW-1:0]      m_awaddr,
  output logic [NS*IDW-1:0]     m_awid,
  output logic [NS*8-1:0]       m_awlen,
  output logic [NS*3-1:0]       m_awsize,
  output logic [NS*2-1:0]       m_awburst,
  output logic [NS-1:0]         m_awvalid,
  input  logic [NS-1:0]         m_awready,
  // slave write data
  output logic [NS*DW-1:0]      m_wdata,
  output logic [NS*DW/8-1:0]    m_wstrb,
  output logic [NS-1:0]         m_wlast,
  output logic [NS-1:0]         m_wvalid,
  input  logic [NS-1:0]         m_wready,
  // slave write response
  input  logic [NS*IDW-1:0]     m_bid,
  input  logic [NS*2-1:0]       m_bresp,
  input  logic [NS-1:0]         m_bvalid,
  output logic [NS-1:0]         m_bready
);

  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

`ifdef AXI_XBAR_DECERR_EN
  localparam logic DECERR = 1'b1;
`else
  localparam logic DECERR = 1'b0;
`endif

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Returns {hit, index}; scanning downwards lets the lowest matching index win.
  function automatic logic [SW:0] decode(input logic [AW-1:0] addr);
    logic [SW:0] res;
    res = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))
        res = {1'b1, SW'(i)};
    end
    return res;
  endfunction

  r_state_t       r_st;
  logic           r_err;
  logic [SW-1:0]  rsel;
  logic [7:0]     r_cnt;
  logic [IDW-1:0] r_id;
  logic           ar_hit;
  logic [SW-1:0]  ar_sel;

  w_state_t       w_st;
  logic           w_err;
  logic [SW-1:0]  wsel;
  logic [IDW-1:0] w_id;
  logic           aw_hit;
  logic [SW-1:0]  aw_sel;

  assign {ar_hit, ar_sel} = decode(s_araddr);
  assign {aw_hit, aw_sel} = decode(s_awaddr);

  // Request payloads go to every slave unchanged.
  assign m_araddr  = {NS{s_araddr}};
  assign m_arid    = {NS{s_arid}};
  assign m_arlen   = {NS{s_arlen}};
  assign m_arsize  = {NS{s_arsize}};
  assign m_arburst = {NS{s_arburst}};
  assign m_awaddr  = {NS{s_awaddr}};
  assign m_awid    = {NS{s_awid}};
  assign m_awlen   = {NS{s_awlen}};
  assign m_awsize  = {NS{s_awsize}};
  assign m_awburst = {NS{s_awburst}};
  assign m_wdata   = {NS{s_wdata}};
  assign m_wstrb   = {NS{s_wstrb}};
  assign m_wlast   = {NS{s_wlast}};

  // Read-path steering: AR to the decoded slave in idle, R back from the latched slave.
  always_comb begin
    m_arvalid = '0;
    s_arready = 1'b0;
    m_rready  = '0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rid     = '0;
    s_rresp   = '0;
    s_rlast   = 1'b0;
    if (rstn) begin
      if (r_st == R_IDLE) begin
        if (ar_hit) begin
          m_arvalid[ar_sel] = s_arvalid;
          s_arready         = m_arready[ar_sel];
        end else begin
          s_arready = DECERR;
        end
      end else if (r_err) begin
        s_rvalid = 1'b1;
        s_rresp  = 2'b11;
        s_rid    = r_id;
        s_rlast  = (r_cnt == 8'd0);
      end else begin
        s_rvalid       = m_rvalid[rsel];
        s_rdata        = m_rdata[rsel*DW +: DW];
        s_rid          = m_rid[rsel*IDW +: IDW];
        s_rresp        = m_rresp[rsel*2 +: 2];
        s_rlast        = m_rlast[rsel];
        m_rready[rsel] = s_rready;
      end
    end
  end

  // Read FSM: one burst in flight; returns to idle on the last accepted beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_st  <= R_IDLE;
      r_err <= 1'b0;
    end else begin
      case (r_st)
        R_IDLE: if (s_arvalid && s_arready) begin
          r_st  <= R_DATA;
          r_err <= !ar_hit;
        end
        R_DATA: if (s_rvalid && s_rready && s_rlast) r_st <= R_IDLE;
        default: r_st <= R_IDLE;
      endcase
    end
  end

  // Read transaction context; the counter only drives the error responder's rlast.
  always_ff @(posedge clk) begin
    if (r_st == R_IDLE && s_arvalid && s_arready) begin
      rsel  <= ar_sel;
      r_cnt <= s_arlen;
      r_id  <= s_arid;
    end else if (r_st == R_DATA && s_rvalid && s_rready) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  // Write-path steering: AW in idle, W during data, B during response; W held off until AW.
  always_comb begin
    m_awvalid = '0;
    s_awready = 1'b0;
    m_wvalid  = '0;
    s_wready  = 1'b0;
    m_bready  = '0;
    s_bvalid  = 1'b0;
    s_bid     = '0;
    s_bresp   = '0;
    if (rstn) begin
      case (w_st)
        W_IDLE: begin
          if (aw_hit) begin
            m_awvalid[aw_sel] = s_awvalid;
            s_awready         = m_awready[aw_sel];
          end else begin
            s_awready = DECERR;
          end
        end
        W_DATA: begin
          if (w_err) begin
            s_wready = 1'b1;
          end else begin
            m_wvalid[wsel] = s_wvalid;
            s_wready       = m_wready[wsel];
          end
        end
        W_RESP: begin
          if (w_err) begin
            s_bvalid = 1'b1;
            s_bresp  = 2'b11;
            s_bid    = w_id;
          end else begin
            s_bvalid       = m_bvalid[wsel];
            s_bid          = m_bid[wsel*IDW +: IDW];
            s_bresp        = m_bresp[wsel*2 +: 2];
            m_bready[wsel] = s_bready;
          end
        end
        default: ;
      endcase
    end
  end

  // Write FSM: address, then data until wlast, then a single response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_st  <= W_IDLE;
      w_err <= 1'b0;
    end else begin
      case (w_st)
        W_IDLE: if (s_awvalid && s_awready) begin
          w_st  <= W_DATA;
          w_err <= !aw_hit;
        end
        W_DATA: if (s_wvalid && s_wready && s_wlast) w_st <= W_RESP;
        W_RESP: if (s_bvalid && s_bready) w_st <= W_IDLE;
        default: w_st <= W_IDLE;
      endcase
    end
  end

  // Write transaction context captured on the AW handshake.
  always_ff @(posedge clk) begin
    if (w_st == W_IDLE && s_awvalid && s_awready) begin
      wsel <= aw_sel;
      w_id <= s_awid;
    end
  end

endmodule

// File: tb/tb_axi_xbar_nport.sv
// Testbench for axi_xbar_nport: NS=2, slave0 window 0x8000_0000/0x8000_0000,
// slave1 window 0x0200_0000/0xFFFF_0000. Behavioural slaves return a data
// pattern tagged with their own index; master tasks compare every beat and
// response against expectations derived from the address map.
`timescale 1ns/1ps
module tb_axi_xbar_nport;
  localparam int NS = 2, AW = 32, DW = 64, IDW = 4;

  logic clk = 1'b0;
  logic rstn;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [IDW-1:0] s_arid, s_awid, s_rid, s_bid;
  logic [7:0] s_arlen, s_awlen;
  logic [2:0] s_arsize, s_awsize;
  logic [1:0] s_arburst, s_awburst, s_rresp, s_bresp;
  logic s_arvalid, s_arready, s_awvalid, s_awready;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic s_rlast, s_rvalid, s_rready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [NS*AW-1:0] m_araddr, m_awaddr;
  logic [NS*IDW-1:0] m_arid, m_awid, m_rid, m_bid;
  logic [NS*8-1:0] m_arlen, m_awlen;
  logic [NS*3-1:0] m_arsize, m_awsize;
  logic [NS*2-1:0] m_arburst, m_awburst, m_rresp, m_bresp;
  logic [NS-1:0] m_arvalid, m_arready, m_awvalid, m_awready, m_rlast, m_rvalid, m_rready;
  logic [NS-1:0] m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NS*DW-1:0] m_rdata, m_wdata;
  logic [NS*DW/8-1:0] m_wstrb;

  axi_xbar_nport #(
    .NS(NS), .AW(AW), .DW(DW), .IDW(IDW),
    .SLV_BASE({32'h0200_0000, 32'h8000_0000}),
    .SLV_MASK({32'hFFFF_0000, 32'h8000_0000})
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Address map seen from the master: first matching window wins.
  bit [31:0] win_base [NS] = '{32'h8000_0000, 32'h0200_0000};
  bit [31:0] win_mask [NS] = '{32'h8000_0000, 32'hFFFF_0000};

  function automatic int ref_slave(input bit [31:0] a);
    for (int i = 0; i < NS; i++) if ((a & win_mask[i]) == win_base[i]) return i;
    return -1;
  endfunction

  function automatic bit [63:0] pat(input int s, input bit [31:0] a, input int b);
    return {8'hA0 + 8'(s), a, 8'(b), 16'h1234};
  endfunction

  bit slv_rand = 1'b0;
  function automatic bit mrand();
    return slv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  typedef struct { int slv; bit [31:0] addr; int len; bit [3:0] id; } ax_t;
  typedef struct { int slv; bit [63:0] data; bit [7:0] strb; bit last; } wb_t;
  ax_t ar_log[$], aw_log[$];
  wb_t w_log[$];

  // Behavioural slaves: one burst at a time per channel, random throttling.
  int sr_busy [NS], sr_len [NS], sr_beat [NS], sw_ph [NS];
  bit [31:0] sr_addr [NS];
  bit [3:0] sr_id [NS], sw_id [NS];

  always begin
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      if (!rstn) begin sr_busy[i] = 0; sw_ph[i] = 0; sr_beat[i] = 0; sr_len[i] = 0; end
      m_arready[i] = !rstn || (sr_busy[i] == 0 && mrand());
      m_rvalid[i]  = rstn && sr_busy[i] != 0 && mrand();
      m_rdata[i*DW +: DW]    = pat(i, sr_addr[i], sr_beat[i]);
      m_rid[i*IDW +: IDW]    = sr_id[i];
      m_rresp[i*2 +: 2]      = 2'b00;
      m_rlast[i]   = (sr_beat[i] == sr_len[i]);
      m_awready[i] = !rstn || (sw_ph[i] == 0 && mrand());
      m_wready[i]  = rstn && sw_ph[i] == 1 && mrand();
      m_bvalid[i]  = rstn && sw_ph[i] == 2 && mrand();
      m_bid[i*IDW +: IDW]    = sw_id[i];
      m_bresp[i*2 +: 2]      = 2'b00;
    end
    #1;
    if (rstn) begin
      for (int i = 0; i < NS; i++) begin
        if (m_arvalid[i] && m_arready[i]) begin
          ar_log.push_back('{i, m_araddr[i*AW +: AW], int'(m_arlen[i*8 +: 8]), m_arid[i*IDW +: IDW]});
          sr_busy[i] = 1; sr_addr[i] = m_araddr[i*AW +: AW];
          sr_len[i] = int'(m_arlen[i*8 +: 8]); sr_beat[i] = 0; sr_id[i] = m_arid[i*IDW +: IDW];
        end else if (m_rvalid[i] && m_rready[i]) begin
          if (sr_beat[i] == sr_len[i]) sr_busy[i] = 0;
          else sr_beat[i]++;
        end
        if (m_awvalid[i] && m_awready[i]) begin
          aw_log.push_back('{i, m_awaddr[i*AW +: AW], int'(m_awlen[i*8 +: 8]), m_awid[i*IDW +: IDW]});
          sw_ph[i] = 1; sw_id[i] = m_awid[i*IDW +: IDW];
        end
        if (m_wvalid[i] && m_wready[i]) begin
          w_log.push_back('{i, m_wdata[i*DW +: DW], m_wstrb[i*8 +: 8], m_wlast[i]});
          if (m_wlast[i]) sw_ph[i] = 2;
        end
        if (m_bvalid[i] && m_bready[i]) sw_ph[i] = 0;
      end
    end
  end

  // Steering monitor: any slave-side valid/ready must point only at the expected slave.
  logic [NS-1:0] rd_mask = '0, wr_mask = '0;
  always begin
    @(negedge clk);
    #2;
    if (m_arvalid != '0) chk("ar_steer", 64'(m_arvalid), 64'(rd_mask));
    if (m_rready  != '0) chk("r_steer",  64'(m_rready),  64'(rd_mask));
    if (m_awvalid != '0) chk("aw_steer", 64'(m_awvalid), 64'(wr_mask));
    if (m_wvalid  != '0) chk("w_steer",  64'(m_wvalid),  64'(wr_mask));
    if (m_bready  != '0) chk("b_steer",  64'(m_bready),  64'(wr_mask));
  end

  task automatic do_read(input bit [31:0] addr, input int len, input bit [3:0] id, input bit imm);
    int s, waits, beat, guard;
    ax_t e;
    s = ref_slave(addr);
    @(negedge clk);
    rd_mask = (s >= 0) ? NS'(1 << s) : '0;
    s_araddr = addr; s_arlen = 8'(len); s_arid = id; s_arsize = 3'd3; s_arburst = 2'b01;
    s_arvalid = 1'b1; s_rready = 1'b0;
    waits = 0;
    forever begin
      #1;
      if (s_arready) break;
      @(negedge clk);
      waits++;
      if (waits > 300) begin
        chk("ar_timeout", 64'(waits), 64'(0)); s_arvalid = 1'b0; return;
      end
    end
    if (imm) chk("ar_back_to_back_wait", 64'(waits), 64'(0));
    beat = 0; guard = 0;
    while (beat <= len) begin
      @(negedge clk);
      s_arvalid = 1'b0;
      s_rready = mrand();
      #1;
      if (s_rvalid && s_rready) begin
        chk("rdata", s_rdata, (s >= 0) ? pat(s, addr, beat) : 64'd0);
        chk("rid",   64'(s_rid),   64'(id));
        chk("rresp", 64'(s_rresp), (s >= 0) ? 64'd0 : 64'd3);
        chk("rlast", 64'(s_rlast), 64'(beat == len));
        beat++;
      end else if (++guard > 500) begin
        chk("r_timeout", 64'(beat), 64'(len + 1)); return;
      end
    end
    chk("ar_ready_on_rlast", 64'(s_arready), 64'd0);
    if (s >= 0) begin
      if (ar_log.size() == 0) chk("ar_route_missing", 64'd0, 64'd1);
      else begin
        e = ar_log.pop_front();
        chk("ar_route_slave", 64'(e.slv), 64'(s));
        chk("ar_route_fields", {e.addr, 8'(e.len), 20'd0, e.id}, {addr, 8'(len), 20'd0, id});
      end
    end else chk("ar_unmapped_no_slave", 64'(ar_log.size()), 64'd0);
  endtask

  task automatic do_write(input bit [31:0] addr, input int len, input bit [3:0] id,
                          input bit [7:0] st0, input bit [7:0] st1, input bit probe);
    int s, waits, beat, guard;
    bit pend;
    bit [63:0] wd;
    bit [7:0] ws;
    wb_t q[$];
    wb_t g;
    ax_t e;
    s = ref_slave(addr);
    pend = 1'b0; wd = '0; ws = '0;
    if (probe) begin pend = 1'b1; wd = {$urandom, $urandom}; ws = st0; end
    @(negedge clk);
    wr_mask = (s >= 0) ? NS'(1 << s) : '0;
    s_awaddr = addr; s_awlen = 8'(len); s_awid = id; s_awsize = 3'd3; s_awburst = 2'b01;
    s_awvalid = 1'b1; s_bready = 1'b0;
    s_wvalid = pend; s_wdata = wd; s_wstrb = ws; s_wlast = (len == 0);
    waits = 0;
    forever begin
      #1;
      if (probe) chk("w_held_before_aw", 64'(s_wready), 64'd0);
      if (s_awready) break;
      @(negedge clk);
      waits++;
      if (waits > 300) begin
        chk("aw_timeout", 64'(waits), 64'(0)); s_awvalid = 1'b0; s_wvalid = 1'b0; return;
      end
    end
    beat = 0; guard = 0;
    while (beat <= len) begin
      @(negedge clk);
      s_awvalid = 1'b0;
      if (!pend && mrand()) begin
        pend = 1'b1; wd = {$urandom, $urandom};
        ws = (beat == 0) ? st0 : (beat == 1) ? st1 : 8'($urandom);
      end
      s_wvalid = pend; s_wdata = wd; s_wstrb = ws; s_wlast = (beat == len);
      #1;
      if (s_wvalid && s_wready) begin
        q.push_back('{s, wd, ws, beat == len});
        pend = 1'b0; beat++;
      end else if (++guard > 500) begin
        chk("w_timeout", 64'(beat), 64'(len + 1)); s_wvalid = 1'b0; return;
      end
    end
    if (probe) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        s_wvalid = 1'b0; s_bready = 1'b0; s_awvalid = 1'b1;
        #1;
        chk("aw_stall_in_resp", {63'd0, s_awready}, 64'd0);
      end
    end
    guard = 0;
    forever begin
      @(negedge clk);
      s_wvalid = 1'b0; s_awvalid = 1'b0; s_bready = mrand();
      #1;
      if (s_bvalid && s_bready) begin
        chk("bid",   64'(s_bid),   64'(id));
        chk("bresp", 64'(s_bresp), (s >= 0) ? 64'd0 : 64'd3);
        break;
      end else if (++guard > 500) begin
        chk("b_timeout", 64'd0, 64'd1); return;
      end
    end
    if (s >= 0) begin
      if (aw_log.size() == 0) chk("aw_route_missing", 64'd0, 64'd1);
      else begin
        e = aw_log.pop_front();
        chk("aw_route_slave", 64'(e.slv), 64'(s));
        chk("aw_route_fields", {e.addr, 8'(e.len), 20'd0, e.id}, {addr, 8'(len), 20'd0, id});
      end
      foreach (q[k]) begin
        if (w_log.size() == 0) begin chk("w_beat_missing", 64'(k), 64'(q.size())); break; end
        g = w_log.pop_front();
        chk("w_slave", 64'(g.slv), 64'(q[k].slv));
        chk("w_data",  g.data, q[k].data);
        chk("w_strb_last", {55'd0, g.last, g.strb}, {55'd0, q[k].last, q[k].strb});
      end
    end else chk("w_unmapped_dropped", 64'(w_log.size() + aw_log.size()), 64'd0);
  endtask

  function automatic bit [31:0] rnd_addr(input int s);
    return (s == 0) ? (32'h8000_0000 | ($urandom & 32'h0FFF_FFF8))
                    : (32'h0200_0000 | ($urandom & 32'h0000_FFF8));
  endfunction

  initial begin
    int bad;
    rstn = 1'b0;
    s_araddr = 32'h8000_0000; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arvalid = 1'b1; s_rready = 1'b1;
    s_awaddr = 32'h8000_0000; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_awvalid = 1'b1; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b1; s_bready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_awready", 64'(s_awready), 64'd0);
    chk("rst_wready",  64'(s_wready),  64'd0);
    chk("rst_rvalid_bvalid", {62'd0, s_rvalid, s_bvalid}, 64'd0);
    chk("rst_m_valids", 64'({m_arvalid, m_awvalid, m_wvalid}), 64'd0);
    chk("rst_m_readies", 64'({m_rready, m_bready}), 64'd0);
    @(negedge clk);
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_rready = 1'b0; s_bready = 1'b0;
    rstn = 1'b1;
    @(negedge clk);

    // Directed: full-throughput burst to slave0, immediate follow-up, then slave1.
    slv_rand = 1'b0;
    do_read(32'h8000_0000, 3, 4'h5, 1'b0);
    do_read(32'h8000_0100, 0, 4'h6, 1'b1);
    do_read(32'h0200_0008, 0, 4'h9, 1'b0);

    // Directed write with fixed strobes, W-before-AW and AW-during-B probes.
    slv_rand = 1'b1;
    do_write(32'h8000_0010, 1, 4'h3, 8'hFF, 8'h0F, 1'b1);

    // Concurrent read to slave1 and write to slave0.
    fork
      do_read(32'h0200_0100, 4, 4'hA, 1'b0);
      do_write(32'h8000_0200, 2, 4'hC, 8'hF0, 8'h3C, 1'b0);
    join

`ifdef AXI_XBAR_DECERR_EN
    do_read(32'h1000_0000, 2, 4'h7, 1'b0);
    do_write(32'h1000_0040, 1, 4'h2, 8'hFF, 8'hFF, 1'b0);
`else
    @(negedge clk);
    rd_mask = '0; wr_mask = '0;
    s_araddr = 32'h1000_0000; s_arlen = 8'd2; s_arvalid = 1'b1;
    s_awaddr = 32'h1000_0040; s_awlen = 8'd0; s_awvalid = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (s_arready || s_awready || m_arvalid != '0 || m_awvalid != '0) bad++;
      @(negedge clk);
    end
    s_arvalid = 1'b0; s_awvalid = 1'b0;
    chk("unmapped_stall_cycles", 64'(bad), 64'd0);
    chk("unmapped_no_slave", 64'(ar_log.size() + aw_log.size()), 64'd0);
`endif

    // Randomized mix of reads, writes and overlapping pairs.
    for (int n = 0; n < 30; n++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) do_read(rnd_addr($urandom_range(0, 1)), $urandom_range(0, 7), 4'($urandom), 1'b0);
      else if (op == 1) do_write(rnd_addr($urandom_range(0, 1)), $urandom_range(0, 7), 4'($urandom),
                                 8'($urandom), 8'($urandom), 1'b0);
      else fork
        do_read(rnd_addr($urandom_range(0, 1)), $urandom_range(0, 7), 4'($urandom), 1'b0);
        do_write(rnd_addr($urandom_range(0, 1)), $urandom_range(0, 7), 4'($urandom),
                 8'($urandom), 8'($urandom), 1'b0);
      join
    end

    // Reset in the middle of a read burst, then a fresh transfer.
    slv_rand = 1'b0;
    @(negedge clk);
    rd_mask = 2'b01;
    s_araddr = 32'h8000_0000; s_arlen = 8'd3; s_arid = 4'h1; s_arvalid = 1'b1; s_rready = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0;
    #1;
    chk("mid_burst_beat1", {62'd0, s_rvalid, s_rready}, 64'd3);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_mid_m_rready", 64'(m_rready), 64'd0);
    chk("rst_mid_arready", 64'(s_arready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    s_rready = 1'b0;
    ar_log.delete(); aw_log.delete(); w_log.delete();
    do_read(32'h8000_0040, 1, 4'hE, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
